// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder stage (two half adders + OR) walked LSB-first
// across WIDTH bits, with a start/busy/done handshake and registered results.

module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic co
);
  assign s  = x ^ y;
  assign co = x & y;
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] a_sh, b_sh, s_sh, s_nxt;
  logic [CW-1:0]    cnt;
  logic             c, c_nxt;
  logic             s1, c1, s2, c2;
  logic             load, step, last;

  half_adder ha1 (.x(a_sh[0]), .y(b_sh[0]), .s(s1), .co(c1));
  half_adder ha2 (.x(s1),      .y(c),       .s(s2), .co(c2));

  assign c_nxt = c1 | c2;
  // Shift-based MSB insert keeps WIDTH=1 legal (no [0:1] slice).
  assign s_nxt = (s_sh >> 1) | (WIDTH'(s2) << (WIDTH - 1));

  always_comb begin
    state_n = state;
    load    = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    case (state)
      IDLE: if (start) begin
        load    = 1'b1;
        state_n = ADD;
      end
      ADD: begin
        step = 1'b1;
        if (cnt == CW'(WIDTH - 1)) begin
          last    = 1'b1;
          state_n = DONE;
        end
      end
      DONE: begin
        if (start) begin
          load    = 1'b1;
          state_n = ADD;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      s_sh      <= '0;
      c         <= 1'b0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
    end else begin
      state <= state_n;
      busy  <= (state_n == ADD);
      done  <= last;
      if (load) begin
        a_sh <= a;
        b_sh <= b;
        s_sh <= '0;
        c    <= 1'b0;
        cnt  <= '0;
      end else if (step) begin
        a_sh <= a_sh >> 1;
        b_sh <= b_sh >> 1;
        s_sh <= s_nxt;
        c    <= c_nxt;
        cnt  <= cnt + CW'(1);
        // Outputs only move on the completion edge; partial sums stay internal.
        if (last) begin
          sum       <= s_nxt;
          carry_out <= c_nxt;
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Randomized self-checking bench: WIDTH=8 instance for handshake/timing scenarios,
// WIDTH=4 instance for an exhaustive sweep; reference is plain integer addition.

module tb_serial_adder_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start8 = 1'b0, start4 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, sum8;
  logic [3:0] a4 = '0, b4 = '0, sum4;
  logic       busy8, done8, co8, busy4, done4, co4;

  int errors = 0;
  int checks = 0;
  logic [8:0] exp_res = '0;  // last completed {carry_out, sum} of the 8-bit unit

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .carry_out(co8));

  serial_adder_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .sum(sum4), .carry_out(co4));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk) reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({busy8, done8, co8, sum8} !== 11'd0 || {busy4, done4, co4, sum4} !== 7'd0) begin
      errors++;
      $display("FAIL reset_state: got8=%b_%b_%b_%h got4=%b_%b_%b_%h want all 0",
               busy8, done8, co8, sum8, busy4, done4, co4, sum4);
    end
    @(negedge clk) reset = 1'b0;
    exp_res = '0;
  endtask

  // One 8-bit add. With scramble, start and a/b are churned during ADD.
  task automatic add8(input logic [7:0] x, input logic [7:0] y, input bit scramble,
                      input string name);
    logic [8:0] want;
    int npulse;
    want = 9'(x) + 9'(y);
    npulse = 0;
    @(negedge clk);
    start8 = 1'b1; a8 = x; b8 = y;
    tick();
    checks++;
    if (busy8 !== 1'b1 || done8 !== 1'b0) begin
      errors++;
      $display("FAIL %s_accept: busy=%b done=%b want busy=1 done=0", name, busy8, done8);
    end
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (scramble && k <= 8) begin
        start8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom);
      end else begin
        start8 = 1'b0;
      end
      tick();
      if (done8 === 1'b1) npulse++;
      checks++;
      if (busy8 !== (k < 8) || done8 !== (k == 8)) begin
        errors++;
        $display("FAIL %s_hs_k%0d: busy=%b done=%b want busy=%b done=%b",
                 name, k, busy8, done8, k < 8, k == 8);
      end
      if (k == 4) begin
        checks++;
        if ({co8, sum8} !== exp_res) begin
          errors++;
          $display("FAIL %s_hold_mid: got=%h want=%h", name, {co8, sum8}, exp_res);
        end
      end
      if (k == 8) begin
        exp_res = want;
        checks++;
        if ({co8, sum8} !== want) begin
          errors++;
          $display("FAIL %s_result: a=%h b=%h got co=%b sum=%h want co=%b sum=%h",
                   name, x, y, co8, sum8, want[8], want[7:0]);
        end
      end
    end
    checks++;
    if (npulse != 1) begin
      errors++;
      $display("FAIL %s_pulses: got=%0d want=1", name, npulse);
    end
  endtask

  task automatic test_basic();
    add8(8'h35, 8'h4A, 1'b0, "basic_35_4a");
    add8(8'hFF, 8'h01, 1'b0, "carry_ff_01");
    add8(8'hFF, 8'hFF, 1'b0, "carry_ff_ff");
    @(negedge clk) a8 = 8'h11; b8 = 8'h22;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if ({co8, sum8} !== 9'h1FE || busy8 !== 1'b0 || done8 !== 1'b0) begin
      errors++;
      $display("FAIL hold_idle: got co=%b sum=%h busy=%b done=%b want co=1 sum=fe busy=0 done=0",
               co8, sum8, busy8, done8);
    end
  endtask

  task automatic test_ignore_start();
    add8(8'h12, 8'h34, 1'b1, "ignore_start");
  endtask

  task automatic test_reset_mid();
    int npulse;
    npulse = 0;
    @(negedge clk) start8 = 1'b1; a8 = 8'h77; b8 = 8'h99;
    tick();
    @(negedge clk) start8 = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    @(negedge clk) reset = 1'b1;
    tick();
    checks++;
    if ({busy8, done8, co8, sum8} !== 11'd0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b co=%b sum=%h want all 0", busy8, done8, co8, sum8);
    end
    exp_res = '0;
    @(negedge clk) reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done8 === 1'b1 || busy8 === 1'b1) npulse++;
    end
    checks++;
    if (npulse != 0) begin
      errors++;
      $display("FAIL reset_abort: activity_cycles=%0d want 0", npulse);
    end
    add8(8'h5C, 8'hA7, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back();
    @(negedge clk) start8 = 1'b1; a8 = 8'h80; b8 = 8'h80;
    tick();
    for (int k = 1; k <= 26; k++) begin
      tick();
      checks++;
      if (done8 !== (k % 9 == 8) || busy8 !== (k % 9 != 8)) begin
        errors++;
        $display("FAIL b2b_k%0d: busy=%b done=%b want busy=%b done=%b",
                 k, busy8, done8, k % 9 != 8, k % 9 == 8);
      end
      if (k % 9 == 8) begin
        checks++;
        if ({co8, sum8} !== 9'h100) begin
          errors++;
          $display("FAIL b2b_result_k%0d: got co=%b sum=%h want co=1 sum=00", k, co8, sum8);
        end
      end
    end
    @(negedge clk) start8 = 1'b0;
    tick();  // DONE -> IDLE
    exp_res = 9'h100;
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++)
      add8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), "random");
  endtask

  task automatic test_exhaustive4();
    int lat;
    logic [4:0] want;
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        want = 5'(x + y);
        @(negedge clk) start4 = 1'b1; a4 = 4'(x); b4 = 4'(y);
        tick();
        @(negedge clk) start4 = 1'b0;
        lat = 0;
        while (done4 !== 1'b1 && lat < 10) begin
          tick();
          lat++;
        end
        checks++;
        if (lat != 4) begin
          errors++;
          $display("FAIL exh4_latency: a=%0d b=%0d got=%0d edges want=4", x, y, lat);
        end
        checks++;
        if ({co4, sum4} !== want) begin
          errors++;
          $display("FAIL exh4_result: a=%0d b=%0d got=%0d want=%0d", x, y, {co4, sum4}, want);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    test_exhaustive4();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial adder controller that sequences one full-adder stage, built from two `half_adder` instances plus an OR on the carries, across a WIDTH-bit operand pair. It processes one bit per clock, LSB first, and presents a registered sum and carry-out with a start/done handshake. It sits between a requester, such as a bench or a small CPU-style datapath, and the shared 1-bit adding resource, trading latency for area.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 1..32
- clk  input  1  rising-edge clock; the only clock
- reset  input  1  synchronous, active-high; sampled on the rising edge of clk
- start  input  1  request; accepted only in IDLE or DONE
- a  input  WIDTH  operand A; sampled on the accepting edge only
- b  input  WIDTH  operand B; sampled on the accepting edge only
- busy  output  1  high while the add is in progress (ADD state)
- done  output  1  one-cycle pulse; result valid
- sum  output  WIDTH  registered result; holds until the next completion
- carry_out  output  1  registered carry out of bit WIDTH-1; holds with sum

## Operation
- FSM states: IDLE, ADD, DONE. Reset state is IDLE.
- IDLE:
  - start=1 → latch a, b into shift registers A_sh, B_sh; clear carry flop c and bit counter cnt.
  - Then go to ADD.
  - start=0 → stay in IDLE.
- ADD, on each edge:
  - Full-adder stage inputs are A_sh[0], B_sh[0] and c.
  - HA1 takes (A_sh[0], B_sh[0]). HA2 takes (HA1.sum, c).
  - Bit result = HA2.sum. Next c = HA1.carry | HA2.carry.
  - Shift A_sh and B_sh right by 1. Shift the bit result into the MSB of partial-sum register S_sh, shifting right.
  - cnt increments by 1.
  - When cnt == WIDTH-1 on this edge (last bit):
    - sum ← final S_sh value, including this bit.
    - carry_out ← next c.
    - done ← 1, busy ← 0, go to DONE.
- DONE:
  - start=1 → accept a new request exactly as in IDLE; go to ADD; done ← 0.
  - start=0 → go to IDLE; done ← 0.
- start in ADD is ignored. No queuing; a, b changes during ADD have no effect.
- sum and carry_out change only on the completion edge. Partial results are never visible on the outputs.
- Arithmetic: {carry_out, sum} = a + b, modulo 2^(WIDTH+1). No carry-in.
- cnt width is $clog2(WIDTH)+1 bits. No wrap occurs because the FSM leaves ADD at WIDTH-1.
- WIDTH=1: a single ADD cycle; behaviour is otherwise identical.

## Timing
- Reset values:
  - busy=0, done=0, sum=0, carry_out=0
  - state=IDLE; A_sh, B_sh, S_sh, c, cnt all 0
- Reset has priority over start and over all state activity.
- Reset asserted mid-ADD:
  - Aborts the operation; no done pulse.
  - sum and carry_out are cleared to 0.
- Latency, with start accepted at edge E0:
  - busy=1 after E0 through edge E(WIDTH-1).
  - done=1 and the result valid after edge E(WIDTH), for exactly one cycle.
  - Start-to-done latency is WIDTH+1 cycles.
- Back-to-back operation:
  - start held high, or reasserted in DONE, yields one result every WIDTH+1 cycles.
  - done is never high for two consecutive cycles.
- busy and done are never high together. Both are registered outputs; there is no combinational path from inputs to outputs.

## Test plan
- WIDTH=8, reset 2 cycles, then a=0x35, b=0x4A, start pulse 1 cycle → busy high 8 cycles; done pulse 9 cycles after the start edge; sum=0x7F, carry_out=0.
- a=0xFF, b=0x01 → sum=0x00, carry_out=1. Then a=0xFF, b=0xFF → sum=0xFE, carry_out=1. sum/carry_out hold their values after done drops until the next completion.
- Mid-ADD, drive start=1 with a=0x00, b=0x00 and change a/b every cycle → the in-flight result of 0x12+0x34 still completes as sum=0x46, carry_out=0; only one done pulse.
- Assert reset for 1 cycle at ADD cycle 4 → busy, done, sum, carry_out all 0 next cycle; no done pulse. A later start adds correctly.
- start held high continuously with a=0x80, b=0x80 → done pulses every 9 cycles; each result is sum=0x00, carry_out=1.
- Exhaustive check at WIDTH=4, all 256 (a,b) pairs → {carry_out, sum} == a+b for every pair; latency 5 cycles each.
